rx_state_watchdog: RTL and testbench

Parametrised receiver watchdog for the OFDM receive chain, replacing the fixed, signal-only watchdog. It sits beside the `dot11` core, observes the receiver state and the sample strobe, and issues a timed reset pulse when:
- any of `NUM_WATCH` low-numbered receiver states persists too long, or
- a decoded header length falls outside a configured window.

A post-reset hold-off keeps the receiver from being reset again before it settles.

---
 rtl/rx_state_watchdog.sv | 136 +++++++++++++
 tb/tb_rx_state_watchdog.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_state_watchdog.sv
// Receiver watchdog: pulses receiver_rst when a watched state dwells too long or a header length is out of window.
// Define RX_WATCHDOG_STATS_EN to build the saturating timeout_cnt / len_viol_cnt event counters.
module rx_state_watchdog #(
  parameter int STATE_WIDTH   = 5,
  parameter int NUM_WATCH     = 4,
  parameter int TO_WIDTH      = 16,
  parameter int RST_PULSE_LEN = 4,
  parameter int HOLDOFF_WIDTH = 12,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          enable,
  input  logic [STATE_WIDTH-1:0]        state,
  input  logic                          iq_valid,
  input  logic                          sig_valid,
  input  logic [15:0]                   pkt_len,
  input  logic [15:0]                   min_len_th,
  input  logic [15:0]                   max_len_th,
  input  logic [NUM_WATCH*TO_WIDTH-1:0] timeout_th,
  input  logic [HOLDOFF_WIDTH-1:0]      holdoff_th,
  output logic                          receiver_rst,
  output logic [1:0]                    rst_cause,
  output logic [STATE_WIDTH-1:0]        timeout_state,
  output logic                          busy,
  output logic [CNT_WIDTH-1:0]          timeout_cnt,
  output logic [CNT_WIDTH-1:0]          len_viol_cnt
);

  typedef enum logic [1:0] {S_MONITOR, S_RESET, S_HOLDOFF} fsm_t;

  localparam int PW = (RST_PULSE_LEN > 1) ? $clog2(RST_PULSE_LEN) : 1;
  localparam logic [PW-1:0] PULSE_LAST = PW'(RST_PULSE_LEN - 1);

  fsm_t                   fsm;
  logic [STATE_WIDTH-1:0] state_prev;
  logic [TO_WIDTH-1:0]    dwell;
  logic [PW-1:0]          pulse_cnt;
  logic [HOLDOFF_WIDTH-1:0] hold_cnt;
  logic [HOLDOFF_WIDTH:0] hold_next;
  logic [TO_WIDTH-1:0]    th_sel;
  logic                   watched;
  logic                   same_state;
  logic                   to_hit;
  logic                   len_hit;
  logic                   hit;

  always_comb begin
    th_sel = '0;
    for (int k = 0; k < NUM_WATCH; k++) begin
      if (state == STATE_WIDTH'(k)) th_sel = timeout_th[k*TO_WIDTH +: TO_WIDTH];
    end
  end

  // The cycle of a state change counts as dwell 0, so it can never satisfy a non-zero limit.
  assign watched    = {1'b0, state} < (STATE_WIDTH+1)'(NUM_WATCH);
  assign same_state = (state == state_prev);
  assign to_hit     = enable && watched && same_state && (th_sel != '0) && (dwell >= th_sel);
  assign len_hit    = enable && sig_valid && ((pkt_len < min_len_th) || (pkt_len > max_len_th));
  assign hit        = (fsm == S_MONITOR) && (to_hit || len_hit);
  assign hold_next  = {1'b0, hold_cnt} + (HOLDOFF_WIDTH+1)'(iq_valid);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_prev <= '0;
      dwell      <= '0;
    end else begin
      state_prev <= state;
      if (fsm != S_MONITOR || hit || !same_state || !watched) begin
        dwell <= '0;
      end else if (enable && iq_valid && dwell != '1) begin
        dwell <= dwell + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fsm           <= S_MONITOR;
      pulse_cnt     <= '0;
      hold_cnt      <= '0;
      receiver_rst  <= 1'b0;
      busy          <= 1'b0;
      rst_cause     <= '0;
      timeout_state <= '0;
    end else begin
      unique case (fsm)
        S_MONITOR: begin
          if (hit) begin
            fsm          <= S_RESET;
            pulse_cnt    <= '0;
            receiver_rst <= 1'b1;
            busy         <= 1'b1;
            rst_cause    <= {len_hit, to_hit};
            if (to_hit) timeout_state <= state;
          end
        end
        S_RESET: begin
          if (pulse_cnt == PULSE_LAST) begin
            fsm          <= S_HOLDOFF;
            receiver_rst <= 1'b0;
            hold_cnt     <= '0;
          end else begin
            pulse_cnt <= pulse_cnt + 1'b1;
          end
        end
        S_HOLDOFF: begin
          // The strobe completing the hold-off count releases monitoring on this same edge.
          if (hold_next >= {1'b0, holdoff_th}) begin
            fsm  <= S_MONITOR;
            busy <= 1'b0;
          end else begin
            hold_cnt <= hold_next[HOLDOFF_WIDTH-1:0];
          end
        end
        default: fsm <= S_MONITOR;
      endcase
    end
  end

`ifdef RX_WATCHDOG_STATS_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      timeout_cnt  <= '0;
      len_viol_cnt <= '0;
    end else begin
      if (hit && to_hit && timeout_cnt != '1) timeout_cnt <= timeout_cnt + 1'b1;
      if (hit && len_hit && len_viol_cnt != '1) len_viol_cnt <= len_viol_cnt + 1'b1;
    end
  end
`else
  assign timeout_cnt  = '0;
  assign len_viol_cnt = '0;
`endif

endmodule

// File: tb/tb_rx_state_watchdog.sv
// Scoreboard bench for rx_state_watchdog: a spec-level model queues expected pulses and busy releases,
// a negedge monitor pops and compares them as the DUT produces them.
`timescale 1ns/1ps
module tb_rx_state_watchdog;

  localparam int SW = 5, NW = 4, TW = 16, PL = 4, HW = 12, CW = 16;
  localparam int TO_MAX = (1 << TW) - 1;
  localparam int CNT_MAX = (1 << CW) - 1;
`ifdef RX_WATCHDOG_STATS_EN
  localparam bit STATS_ON = 1'b1;
`else
  localparam bit STATS_ON = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset, enable, iq_valid, sig_valid;
  logic [SW-1:0] state;
  logic [15:0] pkt_len, min_len_th, max_len_th;
  logic [NW*TW-1:0] timeout_th;
  logic [HW-1:0] holdoff_th;
  logic receiver_rst, busy;
  logic [1:0] rst_cause;
  logic [SW-1:0] timeout_state;
  logic [CW-1:0] timeout_cnt, len_viol_cnt;

  rx_state_watchdog dut (
    .clock(clock), .reset(reset), .enable(enable), .state(state),
    .iq_valid(iq_valid), .sig_valid(sig_valid), .pkt_len(pkt_len),
    .min_len_th(min_len_th), .max_len_th(max_len_th), .timeout_th(timeout_th),
    .holdoff_th(holdoff_th), .receiver_rst(receiver_rst), .rst_cause(rst_cause),
    .timeout_state(timeout_state), .busy(busy), .timeout_cnt(timeout_cnt),
    .len_viol_cnt(len_viol_cnt)
  );

  always #5 clock = ~clock;

  typedef struct {
    int cyc;
    int cause;
    int tstate;
    int tcnt;
    int lcnt;
  } pulse_t;

  pulse_t exp_q[$];
  int     fall_q[$];
  int     checks = 0;
  int     errors = 0;
  int     cyc = 0;
  int     rise_count = 0;
  int     last_rise = -1;

  task automatic check_output(input string name, input longint actual, input longint expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Reference model: walks the spec rules once per clock (monitor / pulse / hold-off phases).
  int m_phase, m_pulse_left, m_hold, m_dwell, m_prev, m_tcnt, m_lcnt, m_tstate;
  int m_s, m_th;
  bit m_to, m_len;
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_phase = 0; m_pulse_left = 0; m_hold = 0; m_dwell = 0; m_prev = 0;
      m_tcnt = 0; m_lcnt = 0; m_tstate = 0;
    end else begin
      cyc++;
      m_s = int'(state);
      if (m_phase == 0) begin
        m_th  = (m_s < NW) ? int'(timeout_th[m_s*TW +: TW]) : 0;
        m_to  = enable && (m_s < NW) && (m_s == m_prev) && (m_th != 0) && (m_dwell >= m_th);
        m_len = enable && sig_valid && ((pkt_len < min_len_th) || (pkt_len > max_len_th));
        if (m_to || m_len) begin
          if (m_to) begin
            m_tstate = m_s;
            if (m_tcnt < CNT_MAX) m_tcnt++;
          end
          if (m_len && m_lcnt < CNT_MAX) m_lcnt++;
          exp_q.push_back('{cyc, (m_len ? 2 : 0) + (m_to ? 1 : 0), m_tstate,
                            STATS_ON ? m_tcnt : 0, STATS_ON ? m_lcnt : 0});
          m_phase = 1; m_pulse_left = PL; m_dwell = 0;
        end else if (m_s != m_prev || m_s >= NW) begin
          m_dwell = 0;
        end else if (enable && iq_valid && m_dwell < TO_MAX) begin
          m_dwell++;
        end
      end else if (m_phase == 1) begin
        m_pulse_left--;
        if (m_pulse_left == 0) begin m_phase = 2; m_hold = 0; end
      end else begin
        if (m_hold + int'(iq_valid) >= int'(holdoff_th)) begin
          m_phase = 0;
          fall_q.push_back(cyc);
        end else begin
          m_hold += int'(iq_valid);
        end
      end
      m_prev = m_s;
    end
  end

  // Monitor: pops an expectation at each receiver_rst rise and each busy release.
  bit rst_q = 0, busy_q = 0, measuring = 0;
  int width = 0;
  pulse_t pe;
  always @(negedge clock) begin
    if (reset) begin
      exp_q.delete(); fall_q.delete();
      measuring = 0; rst_q = 0; busy_q = 0;
    end else begin
      if (receiver_rst && !rst_q) begin
        rise_count++;
        last_rise = cyc;
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("[TB] FAIL unexpected_pulse: got pulse at cycle %0d, expected none", cyc);
        end else begin
          pe = exp_q.pop_front();
          check_output("pulse_cycle", cyc, pe.cyc);
          check_output("rst_cause", rst_cause, pe.cause);
          check_output("timeout_state", timeout_state, pe.tstate);
          check_output("timeout_cnt", timeout_cnt, pe.tcnt);
          check_output("len_viol_cnt", len_viol_cnt, pe.lcnt);
          check_output("busy_at_pulse", busy, 1);
        end
        width = 1; measuring = 1;
      end else if (receiver_rst && measuring) begin
        width++;
      end
      if (!receiver_rst && rst_q && measuring) begin
        check_output("pulse_width", width, PL);
        measuring = 0;
      end
      if (!busy && busy_q) begin
        if (fall_q.size() == 0) begin
          checks++; errors++;
          $display("[TB] FAIL unexpected_busy_fall: got fall at cycle %0d, expected none", cyc);
        end else begin
          check_output("busy_fall_cycle", cyc, fall_q.pop_front());
        end
      end
      rst_q = receiver_rst;
      busy_q = busy;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clock);
      #1;
    end
  endtask

  task automatic set_th(input int k, input int v);
    timeout_th[k*TW +: TW] = TW'(v);
  endtask

  task automatic wait_busy_low(input string tag);
    int n = 0;
    while ((busy || receiver_rst) && n < 5000) begin
      iq_valid = 1'b1;
      tick(1);
      n++;
    end
    iq_valid = 1'b0;
    check_output(tag, busy, 0);
  endtask

  task automatic check_reset_values(input string tag);
    check_output({tag, "_receiver_rst"}, receiver_rst, 0);
    check_output({tag, "_rst_cause"}, rst_cause, 0);
    check_output({tag, "_timeout_state"}, timeout_state, 0);
    check_output({tag, "_busy"}, busy, 0);
    check_output({tag, "_timeout_cnt"}, timeout_cnt, 0);
    check_output({tag, "_len_viol_cnt"}, len_viol_cnt, 0);
  endtask

  task automatic apply_stimulus();
    int base, strobe_cyc, n;
    // Reset state.
    tick(3);
    check_reset_values("reset");
    reset = 1'b0;
    tick(2);

    // Timeout on state 1 with a strobe every 4th clock.
    state = 5'd1; set_th(1, 100);
    tick(1);
    base = rise_count;
    strobe_cyc = 0;
    for (int s = 0; s < 100; s++) begin
      iq_valid = 1'b0; tick(3);
      iq_valid = 1'b1;
      if (s == 99) strobe_cyc = cyc + 1;
      tick(1);
    end
    iq_valid = 1'b0;
    tick(3);
    check_output("timeout_rise_cycle", last_rise, strobe_cyc + 1);
    check_output("timeout_pulse_count", rise_count - base, 1);
    check_output("timeout_cause", rst_cause, 1);
    check_output("timeout_state_1", timeout_state, 1);
    check_output("timeout_cnt_1", timeout_cnt, STATS_ON ? 1 : 0);
    state = 5'd31; set_th(1, 0);
    wait_busy_low("timeout_busy_release");

    // Length window 14..1600.
    base = rise_count;
    pkt_len = 16'd13; sig_valid = 1'b1; tick(1); sig_valid = 1'b0;
    check_output("len_low_cause", rst_cause, 2);
    wait_busy_low("len_busy_release");
    pkt_len = 16'd1600; sig_valid = 1'b1; tick(1);
    pkt_len = 16'd14; tick(1); sig_valid = 1'b0;
    tick(2);
    check_output("len_edge_no_pulse", rise_count - base, 1);
    pkt_len = 16'd1601; sig_valid = 1'b1; tick(1); sig_valid = 1'b0;
    check_output("len_high_cause", rst_cause, 2);
    wait_busy_low("len_high_busy_release");

    // Disabled slice: dwell saturates but never fires.
    base = rise_count;
    state = 5'd2; set_th(2, 0); tick(1);
    iq_valid = 1'b1;
    tick(70000);
    iq_valid = 1'b0;
    check_output("disabled_slice_no_pulse", rise_count - base, 0);
    check_output("disabled_slice_timeout_cnt", timeout_cnt, STATS_ON ? 1 : 0);
    set_th(2, TO_MAX); tick(1);
    check_output("saturated_dwell_pulse", rise_count - base, 1);
    check_output("saturated_timeout_state", timeout_state, 2);
    set_th(2, 0); state = 5'd31;
    wait_busy_low("sat_busy_release");

    // Simultaneous triggers, then a 50-strobe hold-off with violations inside it.
    state = 5'd1; set_th(1, 0); iq_valid = 1'b1; tick(10);
    base = rise_count;
    set_th(1, 5); pkt_len = 16'd2000; sig_valid = 1'b1; holdoff_th = 12'd50;
    tick(1);
    check_output("both_cause", rst_cause, 3);
    set_th(1, 0); state = 5'd31;
    for (int i = 0; i < 53; i++) begin
      iq_valid = 1'b1;
      sig_valid = (i % 5 == 0);
      pkt_len = 16'd5;
      tick(1);
    end
    sig_valid = 1'b0;
    check_output("holdoff_busy_before_50th", busy, 1);
    check_output("holdoff_ignored_violations", rise_count - base, 1);
    tick(1);
    check_output("holdoff_busy_after_50th", busy, 0);
    iq_valid = 1'b0; holdoff_th = 12'd8;
    tick(2);

    // Reset in the 2nd clock of a pulse.
    state = 5'd1; set_th(1, 10);
    n = 0;
    while (!receiver_rst && n < 100) begin iq_valid = 1'b1; tick(1); n++; end
    check_output("reset_test_pulse_seen", receiver_rst, 1);
    @(posedge clock); #1;
    reset = 1'b1; iq_valid = 1'b0;
    #1;
    check_reset_values("mid_pulse_reset");
    tick(2);
    reset = 1'b0;
    tick(1);
    base = rise_count;
    strobe_cyc = 0;
    for (int s = 0; s < 10; s++) begin
      iq_valid = 1'b1;
      if (s == 9) strobe_cyc = cyc + 1;
      tick(1);
    end
    iq_valid = 1'b0;
    tick(2);
    check_output("post_reset_full_dwell", last_rise, strobe_cyc + 1);
    check_output("post_reset_pulse_count", rise_count - base, 1);
    set_th(1, 0); state = 5'd31;
    wait_busy_low("post_reset_busy_release");

    // Randomised traffic against the model.
    min_len_th = 16'd10; max_len_th = 16'd30;
    for (int k = 0; k < NW; k++) set_th(k, $urandom_range(0, 30));
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) state = SW'($urandom_range(0, 5));
      if ($urandom_range(0, 99) == 0) set_th($urandom_range(0, NW-1), $urandom_range(0, 30));
      if ($urandom_range(0, 199) == 0) holdoff_th = HW'($urandom_range(0, 6));
      if ($urandom_range(0, 299) == 0) begin
        min_len_th = 16'($urandom_range(5, 15));
        max_len_th = 16'($urandom_range(20, 35));
      end
      enable    = ($urandom_range(0, 9) != 0);
      iq_valid  = $urandom_range(0, 1) == 1;
      sig_valid = ($urandom_range(0, 11) == 0);
      pkt_len   = 16'($urandom_range(0, 40));
      tick(1);
    end
    enable = 1'b1; sig_valid = 1'b0; timeout_th = '0; state = 5'd31;
    wait_busy_low("random_drain_busy_release");
    tick(PL + 2);
  endtask

  initial begin
    reset = 1'b1; enable = 1'b1; iq_valid = 1'b0; sig_valid = 1'b0;
    state = 5'd31; pkt_len = 16'd100; min_len_th = 16'd14; max_len_th = 16'd1600;
    timeout_th = '0; holdoff_th = 12'd8;
    apply_stimulus();
    check_output("pending_pulses", exp_q.size(), 0);
    check_output("pending_busy_falls", fall_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
